regfile_bypass_sb: RTL and testbench
====================================

# regfile_bypass_sb

Parametrised register file for the pipelined core, the successor to the fixed 16×16, two-read-port register file used in decode.
- Adds a configurable number of read ports and a write-first bypass, so a value written back in a cycle is visible to decode in that same cycle.
- Adds a pending-write scoreboard that raises a stall when decode reads a register whose load result is still in flight.
- Sits in the decode stage. The write-back pipeline register drives the write port; decode control drives the mark/kill ports.

## Interface
Parameters:
- DSIZE, 16, data width in bits
- ASIZE, 4, register address width; NREG = 2**ASIZE registers
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes, marks and kills

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- ren  in  NRD  per-port read enable; only enabled ports can raise stall
- raddr  in  NRD*ASIZE  read addresses, port i at bits [i*ASIZE +: ASIZE]
- rdata  out  NRD*DSIZE  read data, port i at bits [i*DSIZE +: DSIZE]
- wen  in  1  write-back enable
- waddr  in  ASIZE  write-back address
- wdata  in  DSIZE  write-back data
- mark_en  in  1  set the pending bit of mark_addr (a load was issued)
- mark_addr  in  ASIZE  destination register of the issued load
- kill_en  in  1  clear the pending bit of kill_addr (a squashed load)
- kill_addr  in  ASIZE  register whose pending write is cancelled
- stall  out  1  OR of the per-port busy flags
- busy  out  NRD  per-port hazard flag
- pending_cnt  out  ASIZE+1  number of set pending bits

## Operation
State is two register arrays:
- regs[NREG] of DSIZE bits
- pend[NREG] pending bits

Reset (async, rst=1):
- all regs = 0 and all pend = 0.
- Outputs therefore read as: rdata = 0, busy = 0, stall = 0, pending_cnt = 0.

Read path, combinational for each port i, evaluated in this order:
- ZERO_REG=1 and raddr_i==0: rdata_i = 0.
- else wen=1 and waddr==raddr_i (and waddr≠0 when ZERO_REG=1): rdata_i = wdata (bypass).
- else rdata_i = regs[raddr_i].

Hazard, per port i:
- busy_i = ren_i & pend[raddr_i] & ~(wen & waddr==raddr_i).
- A register being written back this cycle is not busy, because the bypass supplies the value.
- Reg 0 is never busy when ZERO_REG=1.

Write, at the rising edge with wen=1:
- regs[waddr] <= wdata.
- pend[waddr] <= 0, unless overridden by a same-cycle mark (see below).

Pending-bit update at the rising edge, priority highest first:
- mark_en & mark_addr==a: pend[a] <= 1. The newest producer wins over a same-cycle write or kill.
- (wen & waddr==a) | (kill_en & kill_addr==a): pend[a] <= 0.
- otherwise: pend[a] holds.

Pending-bit boundary cases:
- Mark of an already-pending register leaves it at 1; the count is unchanged.
- Kill of a non-pending register is a no-op.
- With ZERO_REG=1, marks, kills and writes to address 0 are ignored.

Count:
- pending_cnt = popcount(pend), taken from the registered state.
- Range is 0..NREG (0..NREG-1 when ZERO_REG=1); no wrap.

Write data on a non-pending register is accepted normally. The scoreboard only tracks hazards; it never blocks writes.

## Timing
- Read latency 0 cycles: combinational from raddr, regs, wen/waddr/wdata.
- Write visibility:
  - same cycle through the bypass;
  - from the following cycle through regs.
- stall and busy are combinational from registered pend plus the current ren/raddr/wen/waddr. There is no path from mark_en or kill_en to stall within the same cycle.
- pending_cnt changes only at a clock edge or on reset.
- Reset asserted mid-operation clears state immediately, without waiting for clk. An in-flight write in that cycle is lost.

## Test plan
- Reset then read: rst pulse, then read ports 0/1 at addr 3 and 5 -> rdata=0, stall=0, pending_cnt=0.
- Bypass: wen=1, waddr=4, wdata=16'hBEEF with raddr0=4 in the same cycle -> rdata0=16'hBEEF before the edge; after the edge with wen=0 -> still 16'hBEEF.
- Load-use stall:
  - mark_en on r6; next cycle ren0=1, raddr0=6 -> busy0=1, stall=1, pending_cnt=1.
  - Write r6=16'h0012 -> in that cycle stall=0, rdata0=16'h0012; after the edge pending_cnt=0.
- Simultaneous mark+write on r7 -> after the edge pend[7]=1 and regs[7]=wdata; reading r7 with ren=1 -> stall=1.
- Kill and zero register:
  - Mark r2 and r9 (cnt=2), then kill r9 -> cnt=1.
  - Mark r0 and write r0=16'hFFFF -> cnt stays 1 and r0 reads 0.
- Async reset mid-operation: with r2 pending and regs loaded, raise rst between edges -> stall, pending_cnt and all rdata drop to 0 immediately.

Source files
------------

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass_sb
// Description : Decode-stage register file with write-first bypass and a
//               pending-load scoreboard that flags load-use hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass_sb #(
    parameter int DSIZE    = 16,
    parameter int ASIZE    = 4,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NRD-1:0]         ren,
    input  logic [NRD*ASIZE-1:0]   raddr,
    output logic [NRD*DSIZE-1:0]   rdata,
    input  logic                   wen,
    input  logic [ASIZE-1:0]       waddr,
    input  logic [DSIZE-1:0]       wdata,
    input  logic                   mark_en,
    input  logic [ASIZE-1:0]       mark_addr,
    input  logic                   kill_en,
    input  logic [ASIZE-1:0]       kill_addr,
    output logic                   stall,
    output logic [NRD-1:0]         busy,
    output logic [ASIZE:0]         pending_cnt
);

    localparam int c_nreg = 1 << ASIZE;

    logic [DSIZE-1:0] r_regs [c_nreg];
    logic [c_nreg-1:0] r_pend;
    logic [c_nreg-1:0] w_pend_nxt;
    logic              w_wr_ok;
    logic              w_mark_ok;
    logic              w_kill_ok;
    logic [ASIZE:0]    w_cnt;

    // Register 0 is hard-wired when ZERO_REG is set: all updates to it are dropped.
    assign w_wr_ok   = wen     && !((ZERO_REG != 0) && (waddr     == '0));
    assign w_mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == '0));
    assign w_kill_ok = kill_en && !((ZERO_REG != 0) && (kill_addr == '0));

    // Later assignments take priority: a same-cycle mark beats write-back or kill.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_wr_ok)   w_pend_nxt[waddr]     = 1'b0;
        if (w_kill_ok) w_pend_nxt[kill_addr] = 1'b0;
        if (w_mark_ok) w_pend_nxt[mark_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_nreg; i++) begin
                r_regs[i] <= '0;
            end
            r_pend <= '0;
        end else begin
            if (w_wr_ok) begin
                r_regs[waddr] <= wdata;
            end
            r_pend <= w_pend_nxt;
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < c_nreg; i++) begin
            w_cnt = w_cnt + {{ASIZE{1'b0}}, r_pend[i]};
        end
    end

    assign pending_cnt = w_cnt;

    generate
        for (genvar g = 0; g < NRD; g++) begin : g_rd
            logic [ASIZE-1:0] w_ra;
            logic [DSIZE-1:0] w_rd;

            assign w_ra = raddr[g*ASIZE +: ASIZE];

            always_comb begin
                w_rd = r_regs[w_ra];
                if ((ZERO_REG != 0) && (w_ra == '0)) begin
                    w_rd = '0;
                end else if (w_wr_ok && (waddr == w_ra)) begin
                    w_rd = wdata;
                end
            end

            assign rdata[g*DSIZE +: DSIZE] = w_rd;
            // A register being written back now is covered by the bypass.
            assign busy[g] = ren[g] & r_pend[w_ra] & ~(wen & (waddr == w_ra));
        end
    endgenerate

    assign stall = |busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bypass_sb
// Description : Directed self-checking bench for regfile_bypass_sb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bypass_sb;

    logic        clk;
    logic        rst;
    logic [1:0]  ren;
    logic [7:0]  raddr;
    logic [31:0] rdata;
    logic        wen;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        mark_en;
    logic [3:0]  mark_addr;
    logic        kill_en;
    logic [3:0]  kill_addr;
    logic        stall;
    logic [1:0]  busy;
    logic [4:0]  pending_cnt;

    int checks;
    int errors;

    regfile_bypass_sb #(
        .DSIZE(16), .ASIZE(4), .NRD(2), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .mark_en(mark_en), .mark_addr(mark_addr),
        .kill_en(kill_en), .kill_addr(kill_addr),
        .stall(stall), .busy(busy), .pending_cnt(pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen = 1'b0; mark_en = 1'b0; kill_en = 1'b0;
        waddr = '0; wdata = '0; mark_addr = '0; kill_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ren = 2'b11; raddr = '0; idle();
        tick(); tick();
        rst = 1'b0;
        raddr = {4'd5, 4'd3};
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b expected 00", busy); end
        checks++; if (pending_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt); end
    endtask

    task automatic test_bypass();
        ren = 2'b00; raddr = {4'd1, 4'd4};
        wen = 1'b1; waddr = 4'd4; wdata = 16'hBEEF;
        #1;
        checks++; if (rdata[15:0] !== 16'hBEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h expected BEEF", rdata[15:0]); end
        checks++; if (rdata[31:16] !== 16'h0000) begin errors++; $display("FAIL bypass_other_port: got %h expected 0000", rdata[31:16]); end
        tick();
        idle();
        raddr = {4'd4, 4'd4};
        #1;
        checks++; if (rdata !== {16'hBEEF, 16'hBEEF}) begin errors++; $display("FAIL bypass_after_edge: got %h expected BEEFBEEF", rdata); end
    endtask

    task automatic test_load_use();
        mark_en = 1'b1; mark_addr = 4'd6;
        #1;
        checks++; if (pending_cnt !== 5'd0) begin errors++; $display("FAIL mark_not_before_edge: got %0d expected 0", pending_cnt); end
        tick();
        idle();
        ren = 2'b01; raddr = {4'd6, 4'd6};
        #1;
        checks++; if (busy !== 2'b01) begin errors++; $display("FAIL load_use_busy: got %b expected 01", busy); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_stall: got %b expected 1", stall); end
        checks++; if (pending_cnt !== 5'd1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", pending_cnt); end
        wen = 1'b1; waddr = 4'd6; wdata = 16'h0012;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_clears_stall: got %b expected 0", stall); end
        checks++; if (rdata[15:0] !== 16'h0012) begin errors++; $display("FAIL wb_bypass_data: got %h expected 0012", rdata[15:0]); end
        tick();
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd0) begin errors++; $display("FAIL wb_clears_pend: got %0d expected 0", pending_cnt); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wb_stall_after: got %b expected 0", stall); end
    endtask

    task automatic test_mark_write();
        mark_en = 1'b1; mark_addr = 4'd7;
        wen = 1'b1; waddr = 4'd7; wdata = 16'h1234;
        tick();
        idle();
        ren = 2'b01; raddr = {4'd0, 4'd7};
        #1;
        checks++; if (pending_cnt !== 5'd1) begin errors++; $display("FAIL mark_wins_cnt: got %0d expected 1", pending_cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mark_wins_stall: got %b expected 1", stall); end
        checks++; if (rdata[15:0] !== 16'h1234) begin errors++; $display("FAIL mark_write_data: got %h expected 1234", rdata[15:0]); end
        wen = 1'b1; waddr = 4'd7; wdata = 16'h5678;
        tick();
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd0) begin errors++; $display("FAIL r7_release_cnt: got %0d expected 0", pending_cnt); end
        checks++; if (rdata[15:0] !== 16'h5678) begin errors++; $display("FAIL r7_regs_data: got %h expected 5678", rdata[15:0]); end
    endtask

    task automatic test_kill_zero();
        ren = 2'b00;
        mark_en = 1'b1; mark_addr = 4'd2; tick();
        mark_addr = 4'd9; tick();
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd2) begin errors++; $display("FAIL two_marks_cnt: got %0d expected 2", pending_cnt); end
        mark_en = 1'b1; mark_addr = 4'd2; tick();
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd2) begin errors++; $display("FAIL remark_cnt: got %0d expected 2", pending_cnt); end
        kill_en = 1'b1; kill_addr = 4'd9; tick();
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd1) begin errors++; $display("FAIL kill_cnt: got %0d expected 1", pending_cnt); end
        kill_en = 1'b1; kill_addr = 4'd9; tick();
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd1) begin errors++; $display("FAIL kill_noop_cnt: got %0d expected 1", pending_cnt); end
        ren = 2'b11; raddr = {4'd9, 4'd0};
        mark_en = 1'b1; mark_addr = 4'd0;
        wen = 1'b1; waddr = 4'd0; wdata = 16'hFFFF;
        #1;
        checks++; if (rdata[15:0] !== 16'h0000) begin errors++; $display("FAIL r0_no_bypass: got %h expected 0000", rdata[15:0]); end
        tick();
        idle();
        #1;
        checks++; if (pending_cnt !== 5'd1) begin errors++; $display("FAIL r0_mark_ignored: got %0d expected 1", pending_cnt); end
        checks++; if (rdata[15:0] !== 16'h0000) begin errors++; $display("FAIL r0_reads_zero: got %h expected 0000", rdata[15:0]); end
        checks++; if (busy !== 2'b00) begin errors++; $display("FAIL r0_r9_not_busy: got %b expected 00", busy); end
    endtask

    task automatic test_async_reset();
        ren = 2'b11; raddr = {4'd4, 4'd2};
        #1;
        checks++; if (busy !== 2'b01) begin errors++; $display("FAIL pre_reset_busy: got %b expected 01", busy); end
        checks++; if (rdata[31:16] !== 16'hBEEF) begin errors++; $display("FAIL pre_reset_data: got %h expected BEEF", rdata[31:16]); end
        wen = 1'b1; waddr = 4'd5; wdata = 16'hAAAA;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_rst_stall: got %b expected 0", stall); end
        checks++; if (pending_cnt !== 5'd0) begin errors++; $display("FAIL async_rst_cnt: got %0d expected 0", pending_cnt); end
        idle();
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rst_rdata: got %h expected 0", rdata); end
        tick();
        rst = 1'b0;
        raddr = {4'd5, 4'd7};
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL lost_write_r5_r7: got %h expected 0", rdata); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_bypass();
        test_load_use();
        test_mark_write();
        test_kill_zero();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
